// File: rtl/alu_register_register_mc.sv
// RISC-V R-type ALU: single-cycle base ops plus multi-cycle M-extension ops.
// Uses an iterative shift-add multiplier and a restoring divider, with valid/ready handshakes on both sides.
module alu_register_register_mc #(
    parameter int XLEN     = 32,
    parameter bit ENABLE_M = 1'b1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rd_value,
    output logic            illegal,
    output logic            busy
);
    localparam int SW = $clog2(XLEN);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DIV_BUSY, DONE} state_t;

    state_t            state_q, state_d, target;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [XLEN-1:0]   rd_q, rd_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic              bzero_q, bzero_d;
    logic              illegal_q, illegal_d;

    logic              accept, legal, is_mul, is_div;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, base_res, srl_res;
    logic signed [XLEN-1:0] sra_res;
    logic [SW-1:0]     shamt;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next, mul_fix, div_next;
    logic [XLEN+1:0]   div_trial;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_q, div_r;

    always_comb begin
        legal  = 1'b0;
        is_mul = 1'b0;
        is_div = 1'b0;
        case (funct7)
            7'h00: legal = 1'b1;
            7'h20: legal = (funct3 == 3'd0) || (funct3 == 3'd5);
            7'h01: begin
                legal  = ENABLE_M;
                is_mul = ENABLE_M && !funct3[2];
                is_div = ENABLE_M && funct3[2];
            end
            default: legal = 1'b0;
        endcase
    end

    // M ops run on operand magnitudes; the sign is restored after the last iteration.
    always_comb begin
        a_neg = 1'b0;
        b_neg = 1'b0;
        if (is_mul) begin
            a_neg = rs1_value[XLEN-1] && (funct3[1:0] == 2'd1 || funct3[1:0] == 2'd2);
            b_neg = rs2_value[XLEN-1] && (funct3[1:0] == 2'd1);
        end else if (is_div) begin
            a_neg = rs1_value[XLEN-1] && !funct3[0];
            b_neg = rs2_value[XLEN-1] && !funct3[0];
        end
        a_mag = a_neg ? -rs1_value : rs1_value;
        b_mag = b_neg ? -rs2_value : rs2_value;
    end

    assign shamt   = rs2_value[SW-1:0];
    assign sra_res = $signed(rs1_value) >>> shamt;
    assign srl_res = rs1_value >> shamt;

    always_comb begin
        base_res = '0;
        case (funct3)
            3'd0: base_res = funct7[5] ? rs1_value - rs2_value : rs1_value + rs2_value;
            3'd1: base_res = rs1_value << shamt;
            3'd2: base_res = XLEN'($signed(rs1_value) < $signed(rs2_value));
            3'd3: base_res = XLEN'(rs1_value < rs2_value);
            3'd4: base_res = rs1_value ^ rs2_value;
            3'd5: base_res = funct7[5] ? sra_res : srl_res;
            3'd6: base_res = rs1_value | rs2_value;
            3'd7: base_res = rs1_value & rs2_value;
            default: base_res = '0;
        endcase
    end

    // prod_q holds {acc, multiplier} while multiplying and {remainder, quotient} while dividing.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        mul_fix   = negq_q ? -mul_next : mul_next;
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_trial = {1'b0, div_shift} - {2'b00, mcand_q};
        div_next  = div_trial[XLEN+1] ? {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0}
                                      : {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        div_q     = negq_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
        div_r     = negr_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    end

    always_comb begin
        op_d      = op_q;
        a_d       = a_q;
        mcand_d   = mcand_q;
        prod_d    = prod_q;
        negq_d    = negq_q;
        negr_d    = negr_q;
        bzero_d   = bzero_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        if (accept) begin
            op_d      = funct3;
            a_d       = rs1_value;
            bzero_d   = (rs2_value == '0);
            cnt_d     = CW'(XLEN - 1);
            illegal_d = !legal;
            rd_d      = (legal && !is_mul && !is_div) ? base_res : '0;
            if (is_mul) begin
                mcand_d = a_mag;
                prod_d  = {{XLEN{1'b0}}, b_mag};
                negq_d  = a_neg ^ b_neg;
            end else if (is_div) begin
                mcand_d = b_mag;
                prod_d  = {{XLEN{1'b0}}, a_mag};
                negq_d  = a_neg ^ b_neg;
                negr_d  = a_neg;
            end
        end else if (state_q == MUL_BUSY || state_q == DIV_BUSY) begin
            prod_d = (state_q == MUL_BUSY) ? mul_next : div_next;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - 1'b1;
            end else if (state_q == MUL_BUSY) begin
                rd_d = (op_q[1:0] == 2'd0) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
            end else if (bzero_q) begin
                rd_d = op_q[1] ? a_q : '1;
            end else begin
                rd_d = op_q[1] ? div_r : div_q;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            a_q       <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            negq_q    <= 1'b0;
            negr_q    <= 1'b0;
            bzero_q   <= 1'b0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            mcand_q   <= mcand_d;
            prod_q    <= prod_d;
            negq_q    <= negq_d;
            negr_q    <= negr_d;
            bzero_q   <= bzero_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        target = is_mul ? MUL_BUSY : (is_div ? DIV_BUSY : DONE);
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept) state_d = target;
            MUL_BUSY: if (cnt_q == '0) state_d = DONE;
            DIV_BUSY: if (cnt_q == '0) state_d = DONE;
            DONE:     if (out_ready) state_d = accept ? target : IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !reset && ((state_q == IDLE) || (state_q == DONE && out_ready));
        out_valid = (state_q == DONE);
        busy      = (state_q == MUL_BUSY) || (state_q == DIV_BUSY);
        rd_value  = rd_q;
        illegal   = illegal_q;
    end

    assign accept = in_valid && in_ready;

endmodule
